// File: rtl/armleocpu_tlb_asid.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_tlb_asid
// Brief    : Set-associative Sv32 TLB. It maps vaddr[31:12] to ptag[21:0]
//            with 8-bit PTE metadata. Resolve results are registered, with a
//            latency of one cycle.
//            Optional ASID tagging is enabled by the ARMLEOCPU_TLB_ASID_EN
//            macro.
// Revision : 1.0 - initial release
// ============================================================================
module armleocpu_tlb_asid #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS      = 3,
  parameter int ASID_W    = 9,
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cmd,
  input  logic [19:0]       vaddr,
  input  logic [ASID_W-1:0] asid,
  input  logic [7:0]        new_entry_metadata,
  input  logic [21:0]       new_entry_ptag,
  output logic              resolve_valid,
  output logic              hit,
  output logic [7:0]        resolve_metadata,
  output logic [21:0]       resolve_ptag,
  output logic [WAY_W-1:0]  resolve_way
);

  localparam int       SETS           = 1 << ENTRIES_W;
  localparam int       VTAG_W         = 20 - ENTRIES_W;
  localparam logic [2:0] C_CMD_RESOLVE  = 3'd1;
  localparam logic [2:0] C_CMD_NEW      = 3'd2;
  localparam logic [2:0] C_CMD_INV_ALL  = 3'd3;
  localparam logic [2:0] C_CMD_INV_VA   = 3'd4;
  localparam logic [WAY_W-1:0] C_LAST_WAY = WAY_W'(WAYS - 1);

  // Storage. Only valid bits and victim pointers carry a reset.
  logic [WAYS-1:0]   r_valid  [SETS];
  logic [WAY_W-1:0]  r_victim [SETS];
  logic [VTAG_W-1:0] r_vtag   [SETS][WAYS];
  logic [21:0]       r_ptag   [SETS][WAYS];
  logic [7:1]        r_meta   [SETS][WAYS];
`ifdef ARMLEOCPU_TLB_ASID_EN
  logic [ASID_W-1:0] r_asid   [SETS][WAYS];
`else
  logic              w_unused_asid;
  assign w_unused_asid = ^asid;
`endif

  logic [ENTRIES_W-1:0] w_index;
  logic [VTAG_W-1:0]    w_vtag;
  logic [WAYS-1:0]      w_match;
  logic                 w_any_match;
  logic [WAY_W-1:0]     w_match_way;
  logic                 w_any_invalid;
  logic [WAY_W-1:0]     w_invalid_way;
  logic [WAY_W-1:0]     w_target;

  assign w_index = vaddr[ENTRIES_W-1:0];
  assign w_vtag  = vaddr[19:ENTRIES_W];

  // A global mapping (G bit) matches any ASID.
  for (genvar g = 0; g < WAYS; g++) begin : g_match
`ifdef ARMLEOCPU_TLB_ASID_EN
    assign w_match[g] = r_valid[w_index][g] && (r_vtag[w_index][g] == w_vtag) &&
                        (r_meta[w_index][g][5] || (r_asid[w_index][g] == asid));
`else
    assign w_match[g] = r_valid[w_index][g] && (r_vtag[w_index][g] == w_vtag);
`endif
  end

  // Priority encoders: scanning downward leaves the lowest-numbered way.
  always_comb begin
    w_any_match   = 1'b0;
    w_match_way   = '0;
    w_any_invalid = 1'b0;
    w_invalid_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_any_match = 1'b1;
        w_match_way = WAY_W'(i);
      end
      if (!r_valid[w_index][i]) begin
        w_any_invalid = 1'b1;
        w_invalid_way = WAY_W'(i);
      end
    end
  end

  // Refill target. An existing match is reused so duplicates never form.
  assign w_target = w_any_match   ? w_match_way   :
                    w_any_invalid ? w_invalid_way : r_victim[w_index];

  // Valid bits and victim pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s]  <= '0;
        r_victim[s] <= '0;
      end
    end else begin
      case (cmd)
        C_CMD_NEW: begin
          r_valid[w_index][w_target] <= new_entry_metadata[0];
          if (w_target == r_victim[w_index])
            r_victim[w_index] <= (r_victim[w_index] == C_LAST_WAY) ? '0 : r_victim[w_index] + 1'b1;
        end
        C_CMD_INV_ALL: begin
          for (int s = 0; s < SETS; s++) begin
            r_valid[s]  <= '0;
            r_victim[s] <= '0;
          end
        end
        C_CMD_INV_VA: r_valid[w_index] <= r_valid[w_index] & ~w_match;
        default: ;
      endcase
    end
  end

  // Entry payload. Writes during reset land in invalid ways and are harmless.
  always_ff @(posedge clk) begin
    if (cmd == C_CMD_NEW) begin
      r_vtag[w_index][w_target] <= w_vtag;
      r_ptag[w_index][w_target] <= new_entry_ptag;
      r_meta[w_index][w_target] <= new_entry_metadata[7:1];
`ifdef ARMLEOCPU_TLB_ASID_EN
      r_asid[w_index][w_target] <= asid;
`endif
    end
  end

  // Registered resolve result; anything other than RESOLVE clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolve_valid    <= 1'b0;
      hit              <= 1'b0;
      resolve_metadata <= '0;
      resolve_ptag     <= '0;
      resolve_way      <= '0;
    end else if (cmd == C_CMD_RESOLVE) begin
      resolve_valid    <= 1'b1;
      hit              <= w_any_match;
      resolve_metadata <= w_any_match ? {r_meta[w_index][w_match_way], 1'b1} : 8'h00;
      resolve_ptag     <= w_any_match ? r_ptag[w_index][w_match_way] : 22'h0;
      resolve_way      <= w_any_match ? w_match_way : '0;
    end else begin
      resolve_valid    <= 1'b0;
      hit              <= 1'b0;
      resolve_metadata <= '0;
      resolve_ptag     <= '0;
      resolve_way      <= '0;
    end
  end

endmodule
`default_nettype wire
